lcd_spi_receiver: RTL and testbench



---
 rtl/lcd_spi_receiver_pkg.sv | 21 ++
 rtl/lcd_spi_receiver_if.sv | 30 +++
 rtl/lcd_spi_receiver_spi_byte_rx.sv | 69 ++++++
 rtl/lcd_spi_receiver.sv | 150 +++++++++++++++
 tb/tb_lcd_spi_receiver.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_spi_receiver_pkg.sv
// Shared definitions for the LCD serial panel receiver: command opcodes and
// decoder states.
package lcd_pkg;

   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   typedef enum logic [2:0] {
      IDLE,
      CASET,
      PASET,
      RAM_HI,
      RAM_LO
   } rx_state_t;

endpackage

// File: rtl/lcd_spi_receiver_if.sv
// LCD link bundle: 4-wire serial input from the console driver plus the
// framebuffer write port and panel status produced by the receiver.
interface lcd_spi_receiver_if #(
   parameter int AW = 17
);
   logic          scl;
   logic          sda;
   logic          cs;
   logic          rs;
   logic          pix_we;
   logic [AW-1:0] pix_addr;
   logic [15:0]   pix_data;
   logic          frame_done;
   logic          cmd_valid;
   logic [7:0]    cmd_byte;
   logic          awake;
   logic          disp_on;

   modport master (
      output scl, sda, cs, rs,
      input  pix_we, pix_addr, pix_data, frame_done,
      input  cmd_valid, cmd_byte, awake, disp_on
   );

   modport slave (
      input  scl, sda, cs, rs,
      output pix_we, pix_addr, pix_data, frame_done,
      output cmd_valid, cmd_byte, awake, disp_on
   );
endinterface

// File: rtl/lcd_spi_receiver_spi_byte_rx.sv
// Oversampled serial byte deserialiser: synchronises the link, detects scl
// rises and emits one strobe per completed 8-bit byte with its rs flag.
module spi_byte_rx (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda,
   input  logic       cs,
   input  logic       rs,
   output logic       byte_strb,
   output logic [7:0] rx_byte,
   output logic       is_data
);

   logic [1:0] scl_sync, sda_sync, cs_sync, rs_sync;
   logic       scl_prev;
   logic       scl_rise;
   logic       armed;
   logic [2:0] bit_cnt;
   logic [6:0] shift;

   assign scl_rise = scl_sync[1] & ~scl_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync <= '0;
         sda_sync <= '0;
         cs_sync  <= '0;
         rs_sync  <= '0;
         scl_prev <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
         cs_sync  <= {cs_sync[0], cs};
         rs_sync  <= {rs_sync[0], rs};
         scl_prev <= scl_sync[1];
      end
   end

   // Bits are only accepted after cs has been seen high, so a reset taken
   // mid-byte realigns on the next cs high->low instead of mid-stream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed     <= 1'b0;
         bit_cnt   <= '0;
         shift     <= '0;
         byte_strb <= 1'b0;
         rx_byte   <= '0;
         is_data   <= 1'b0;
      end else begin
         byte_strb <= 1'b0;
         if (cs_sync[1]) begin
            armed   <= 1'b1;
            bit_cnt <= '0;
         end else if (armed && scl_rise) begin
            shift <= {shift[5:0], sda_sync[1]};
            if (bit_cnt == 3'd7) begin
               bit_cnt   <= '0;
               byte_strb <= 1'b1;
               rx_byte   <= {shift, sda_sync[1]};
               is_data   <= rs_sync[1];
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/lcd_spi_receiver.sv
// Panel-side LCD link receiver: decodes the command subset, tracks the
// column/page window and turns RGB565 byte pairs into framebuffer writes.
module lcd_spi_receiver
   import lcd_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int AW     = $clog2(WIDTH * HEIGHT)
) (
   input logic              clk,
   input logic              reset,
   lcd_spi_receiver_if.slave lcd
);

   localparam logic [15:0] W16 = 16'(WIDTH);
   localparam logic [15:0] H16 = 16'(HEIGHT);

   logic          byte_strb;
   logic [7:0]    rx_byte;
   logic          is_data;

   rx_state_t     state;
   logic [1:0]    pidx;
   logic [15:0]   param_start;
   logic [7:0]    param_end_hi;
   logic [15:0]   xs, xe, ys, ye, x, y;
   logic [7:0]    hi;
   logic [AW-1:0] addr_c;

   logic          pix_we, frame_done, cmd_valid, awake, disp_on;
   logic [AW-1:0] pix_addr;
   logic [15:0]   pix_data;
   logic [7:0]    cmd_byte;

   spi_byte_rx u_rx (
      .clk       (clk),
      .reset     (reset),
      .scl       (lcd.scl),
      .sda       (lcd.sda),
      .cs        (lcd.cs),
      .rs        (lcd.rs),
      .byte_strb (byte_strb),
      .rx_byte   (rx_byte),
      .is_data   (is_data)
   );

   // Out-of-range coordinates may alias here; such writes are suppressed.
   assign addr_c = AW'(y) * AW'(WIDTH) + AW'(x);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pidx         <= '0;
         param_start  <= '0;
         param_end_hi <= '0;
         xs           <= '0;
         xe           <= W16 - 16'd1;
         ys           <= '0;
         ye           <= H16 - 16'd1;
         x            <= '0;
         y            <= '0;
         hi           <= '0;
         pix_we       <= 1'b0;
         pix_addr     <= '0;
         pix_data     <= '0;
         frame_done   <= 1'b0;
         cmd_valid    <= 1'b0;
         cmd_byte     <= '0;
         awake        <= 1'b0;
         disp_on      <= 1'b0;
      end else begin
         pix_we     <= 1'b0;
         frame_done <= 1'b0;
         cmd_valid  <= 1'b0;
         if (byte_strb && !is_data) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= rx_byte;
            pidx      <= '0;
            state     <= IDLE;
            case (rx_byte)
               CMD_SLPOUT:  awake   <= 1'b1;
               CMD_SLPIN:   awake   <= 1'b0;
               CMD_DISPON:  disp_on <= 1'b1;
               CMD_DISPOFF: disp_on <= 1'b0;
               CMD_CASET:   state   <= CASET;
               CMD_PASET:   state   <= PASET;
               CMD_RAMWR: begin
                  x     <= xs;
                  y     <= ys;
                  state <= RAM_HI;
               end
               default: ;
            endcase
         end else if (byte_strb) begin
            case (state)
               CASET, PASET: begin
                  pidx <= pidx + 2'd1;
                  case (pidx)
                     2'd0: param_start[15:8] <= rx_byte;
                     2'd1: param_start[7:0]  <= rx_byte;
                     2'd2: param_end_hi      <= rx_byte;
                     default: begin
                        if (state == CASET) begin
                           xs <= param_start;
                           xe <= {param_end_hi, rx_byte};
                        end else begin
                           ys <= param_start;
                           ye <= {param_end_hi, rx_byte};
                        end
                        state <= IDLE;
                     end
                  endcase
               end
               RAM_HI: begin
                  hi    <= rx_byte;
                  state <= RAM_LO;
               end
               RAM_LO: begin
                  pix_we   <= (x < W16) && (y < H16);
                  pix_addr <= addr_c;
                  pix_data <= {hi, rx_byte};
                  if (x >= xe) begin
                     x <= xs;
                     if (y >= ye) begin
                        y          <= ys;
                        frame_done <= 1'b1;
                     end else begin
                        y <= y + 16'd1;
                     end
                  end else begin
                     x <= x + 16'd1;
                  end
                  state <= RAM_HI;
               end
               default: ;
            endcase
         end
      end
   end

   assign lcd.pix_we     = pix_we;
   assign lcd.pix_addr   = pix_addr;
   assign lcd.pix_data   = pix_data;
   assign lcd.frame_done = frame_done;
   assign lcd.cmd_valid  = cmd_valid;
   assign lcd.cmd_byte   = cmd_byte;
   assign lcd.awake      = awake;
   assign lcd.disp_on    = disp_on;

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Scoreboard bench for lcd_spi_receiver: directed serial traffic with
// hand-computed pixel and command expectations.
module tb_lcd_spi_receiver;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 240;
   localparam int AW     = $clog2(WIDTH * HEIGHT);

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
      logic          fd;
   } pix_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   pix_t pq[$];
   logic [7:0] cq[$];

   lcd_spi_receiver_if #(.AW(AW)) lcd ();

   lcd_spi_receiver #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .AW     (AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .lcd   (lcd)
   );

   always #5 clk = ~clk;

   // Monitor: pops expectations whenever the DUT presents a write or command.
   always @(negedge clk) begin
      if (!reset) begin
         if (lcd.pix_we) begin
            tests++;
            if (pq.size() == 0) begin
               fails++;
               $display("FAIL pix_unexpected: got addr=%0d data=%h fd=%0b, none expected",
                        lcd.pix_addr, lcd.pix_data, lcd.frame_done);
            end else begin
               pix_t e;
               e = pq.pop_front();
               if (lcd.pix_addr !== e.addr || lcd.pix_data !== e.data || lcd.frame_done !== e.fd) begin
                  fails++;
                  $display("FAIL pix_write: got addr=%0d data=%h fd=%0b, want addr=%0d data=%h fd=%0b",
                           lcd.pix_addr, lcd.pix_data, lcd.frame_done, e.addr, e.data, e.fd);
               end
            end
         end else if (lcd.frame_done) begin
            tests++;
            fails++;
            $display("FAIL frame_done_alone: got frame_done=1 with pix_we=0, want 0");
         end
         if (lcd.cmd_valid) begin
            tests++;
            if (cq.size() == 0) begin
               fails++;
               $display("FAIL cmd_unexpected: got cmd_byte=%h, none expected", lcd.cmd_byte);
            end else begin
               logic [7:0] ec;
               ec = cq.pop_front();
               if (lcd.cmd_byte !== ec) begin
                  fails++;
                  $display("FAIL cmd_byte: got %h, want %h", lcd.cmd_byte, ec);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic exp_pix(input int addr, input logic [15:0] data, input logic fd);
      pix_t e;
      e.addr = AW'(addr);
      e.data = data;
      e.fd   = fd;
      pq.push_back(e);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input logic d);
      for (int i = 7; i > 7 - n; i--) begin
         @(negedge clk);
         lcd.sda = b[i];
         lcd.rs  = d;
         repeat (4) @(negedge clk);
         lcd.scl = 1'b1;
         repeat (4) @(negedge clk);
         lcd.scl = 1'b0;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      cq.push_back(b);
      send_bits(b, 8, 1'b0);
   endtask

   task automatic send_data(input logic [7:0] b);
      send_bits(b, 8, 1'b1);
   endtask

   task automatic send_pix(input logic [15:0] p);
      send_data(p[15:8]);
      send_data(p[7:0]);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pix_we"},     32'(lcd.pix_we), 0);
      check({tag, "_pix_addr"},   32'(lcd.pix_addr), 0);
      check({tag, "_pix_data"},   32'(lcd.pix_data), 0);
      check({tag, "_frame_done"}, 32'(lcd.frame_done), 0);
      check({tag, "_cmd_valid"},  32'(lcd.cmd_valid), 0);
      check({tag, "_cmd_byte"},   32'(lcd.cmd_byte), 0);
      check({tag, "_awake"},      32'(lcd.awake), 0);
      check({tag, "_disp_on"},    32'(lcd.disp_on), 0);
   endtask

   initial begin
      reset   = 1'b1;
      lcd.scl = 1'b0;
      lcd.sda = 1'b0;
      lcd.cs  = 1'b1;
      lcd.rs  = 1'b0;
      repeat (5) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      repeat (6) @(negedge clk);
      lcd.cs = 1'b0;
      repeat (4) @(negedge clk);

      // Power state commands
      send_cmd(8'h11);
      check("awake_after_slpout", 32'(lcd.awake), 1);
      send_cmd(8'h29);
      check("disp_on_after_dispon", 32'(lcd.disp_on), 1);

      // Memory write with the default full-panel window
      send_cmd(8'h2C);
      exp_pix(0, 16'hF800, 1'b0);
      exp_pix(1, 16'h07E0, 1'b0);
      send_pix(16'hF800);
      send_pix(16'h07E0);

      // 2x1 window at columns 10..11, row 5: wraps after two pixels
      send_cmd(8'h2A);
      send_data(8'h00); send_data(8'h0A); send_data(8'h00); send_data(8'h0B);
      send_cmd(8'h2B);
      send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h05);
      send_cmd(8'h2C);
      exp_pix(1610, 16'h1234, 1'b0);
      exp_pix(1611, 16'hABCD, 1'b1);
      exp_pix(1610, 16'h5A5A, 1'b0);
      send_pix(16'h1234);
      send_pix(16'hABCD);
      send_pix(16'h5A5A);

      // Partial byte discarded by cs high
      send_bits(8'hFF, 5, 1'b0);
      lcd.cs = 1'b1;
      repeat (8) @(negedge clk);
      lcd.cs = 1'b0;
      repeat (4) @(negedge clk);
      send_cmd(8'h2C);
      check("cmd_byte_after_partial", 32'(lcd.cmd_byte), 32'h2C);

      // Command aborts a half pixel; data in IDLE is ignored
      send_cmd(8'h2C);
      send_data(8'h77);
      send_cmd(8'h00);
      send_data(8'h12);
      send_data(8'h34);
      send_data(8'h56);

      send_cmd(8'h28);
      check("disp_on_after_dispoff", 32'(lcd.disp_on), 0);
      send_cmd(8'h10);
      check("awake_after_slpin", 32'(lcd.awake), 0);

      // 100 pixels into the 2x1 window, then reset
      send_cmd(8'h2C);
      for (int i = 0; i < 100; i++) begin
         exp_pix(1610 + (i % 2), 16'(i * 16'h0101 + 1), (i % 2) == 1);
         send_pix(16'(i * 16'h0101 + 1));
      end
      repeat (10) @(negedge clk);
      check("pix_drain_before_reset", 32'(pq.size()), 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("midreset");
      reset = 1'b0;
      lcd.cs = 1'b1;
      repeat (8) @(negedge clk);
      lcd.cs = 1'b0;
      repeat (4) @(negedge clk);
      send_cmd(8'h2C);
      exp_pix(0, 16'hC0DE, 1'b0);
      exp_pix(1, 16'hBEEF, 1'b0);
      send_pix(16'hC0DE);
      send_pix(16'hBEEF);

      repeat (20) @(negedge clk);
      check("pix_queue_drained", 32'(pq.size()), 0);
      check("cmd_queue_drained", 32'(cq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
